// File: rtl/corrdet_resultpack_if.sv
// Result-in / byte-out handshake bundle for corrdet_resultpack.
// slave = packer side, master = producer/host side.
interface corrdet_resultpack_if #(
   parameter int IDX_W  = 9,
   parameter int DATA_W = 8
);
   logic              i_resultValid;
   logic              o_resultReady;
   logic [IDX_W-1:0]  i_resultIdx;
   logic [DATA_W-1:0] i_resultData;
   logic              i_resultArq;
   logic              o_byteValid;
   logic              i_byteReady;
   logic [7:0]        o_byteData;

   modport slave (
      input  i_resultValid, i_resultIdx, i_resultData,
      input  i_resultArq, i_byteReady,
      output o_resultReady, o_byteValid, o_byteData
   );

   modport master (
      output i_resultValid, i_resultIdx, i_resultData,
      output i_resultArq, i_byteReady,
      input  o_resultReady, o_byteValid, o_byteData
   );
endinterface

// File: rtl/corrdet_resultpack.sv
// Packs (idx, data, arq) results into byte records for the host link,
// inserting a 2-byte window record whenever arq toggles.
module corrdet_resultpack #(
   parameter int N_RESULTS = 276,
   parameter int IDX_W     = $clog2(N_RESULTS),
   parameter int DATA_W    = 8
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_cg,
   corrdet_resultpack_if.slave  bus,
   output logic [7:0]           o_windowCount,
   output logic                 o_busy
);
   typedef enum logic [2:0] {
      S_IDLE, S_WIN0, S_WIN1,
      S_RES0, S_RES1, S_RES2, S_RES3
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] idx_q;
   logic [7:0]  data_q;
   logic        last_arq_q;
   logic [7:0]  wcnt_q;
   logic        accept, fire, toggle;

   assign accept = bus.o_resultReady & bus.i_resultValid;
   assign fire   = bus.o_byteValid & bus.i_byteReady;
   assign toggle = bus.i_resultArq != last_arq_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_IDLE;
      end else if (i_cg) begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (accept) state_d = toggle ? S_WIN0 : S_RES0;
         S_WIN0: if (fire) state_d = S_WIN1;
         S_WIN1: if (fire) state_d = S_RES0;
         S_RES0: if (fire) state_d = S_RES1;
         S_RES1: if (fire) state_d = S_RES2;
         S_RES2: if (fire) state_d = S_RES3;
         S_RES3: if (fire) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // accept already implies i_cg, so capture freezes with the clock gate
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         idx_q      <= '0;
         data_q     <= '0;
         last_arq_q <= 1'b0;
         wcnt_q     <= '0;
      end else if (accept) begin
         idx_q  <= 16'(bus.i_resultIdx);
         data_q <= 8'(bus.i_resultData);
         if (toggle) begin
            last_arq_q <= bus.i_resultArq;
            wcnt_q     <= wcnt_q + 8'd1;
         end
      end
   end

   always_comb begin
      bus.o_resultReady = i_cg & (state_q == S_IDLE);
      bus.o_byteValid   = i_cg & (state_q != S_IDLE);
      bus.o_byteData    = 8'h00;
      unique case (state_q)
         S_WIN0:  bus.o_byteData = 8'h01;
         S_WIN1:  bus.o_byteData = wcnt_q;
         S_RES1:  bus.o_byteData = idx_q[7:0];
         S_RES2:  bus.o_byteData = idx_q[15:8];
         S_RES3:  bus.o_byteData = data_q;
         default: bus.o_byteData = 8'h00;
      endcase
   end

   assign o_windowCount = wcnt_q;
   assign o_busy        = state_q != S_IDLE;
endmodule

// File: tb/tb_corrdet_resultpack.sv
// Bench for corrdet_resultpack: byte-queue reference model checked every
// cycle, plus directed literal records and randomized traffic.
module tb_corrdet_resultpack;
   localparam int IDX_W = 9;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cg  = 1'b1;
   logic [7:0] wcnt;
   logic       busy;

   corrdet_resultpack_if #(.IDX_W(IDX_W), .DATA_W(8)) bus ();

   corrdet_resultpack #(.N_RESULTS(276), .IDX_W(IDX_W), .DATA_W(8)) dut (
      .i_clk(clk),
      .i_rst(rst),
      .i_cg(cg),
      .bus(bus),
      .o_windowCount(wcnt),
      .o_busy(busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit rnd_en = 1'b0;

   byte unsigned mq[$];
   int           m_cnt  = 0;
   bit           m_last = 1'b0;
   byte unsigned obs[$];
   int           obs_cyc[$];
   int           acc_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   // reference model: queue of bytes still owed to the host
   always @(negedge clk) begin
      bit empty;
      int iv;
      empty = mq.size() == 0;
      chk("byteValid", bus.o_byteValid, cg && !empty);
      if (cg && !empty) chk("byteData", bus.o_byteData, mq[0]);
      chk("resultReady", bus.o_resultReady, cg && empty);
      chk("windowCount", wcnt, m_cnt);
      chk("busy", busy, !empty);
      if (bus.o_byteValid && bus.i_byteReady) begin
         obs.push_back(bus.o_byteData);
         obs_cyc.push_back(cyc);
      end
      if (rst) begin
         mq.delete();
         m_cnt  = 0;
         m_last = 1'b0;
      end else if (cg) begin
         if (!empty && bus.i_byteReady) void'(mq.pop_front());
         if (empty && bus.i_resultValid) begin
            acc_cyc = cyc;
            if (bus.i_resultArq != m_last) begin
               m_last = bus.i_resultArq;
               m_cnt  = (m_cnt + 1) % 256;
               mq.push_back(8'h01);
               mq.push_back(8'(m_cnt));
            end
            iv = int'(bus.i_resultIdx);
            mq.push_back(8'h00);
            mq.push_back(8'(iv & 255));
            mq.push_back(8'((iv >> 8) & 255));
            mq.push_back(8'(bus.i_resultData));
         end
      end
   end

   always @(posedge clk) begin
      if (rnd_en) begin
         #1;
         bus.i_byteReady = $urandom_range(0, 3) != 0;
         cg = $urandom_range(0, 9) != 0;
      end
   end

   task automatic send(input int idx, input int data, input bit arq);
      bit acc;
      acc = 1'b0;
      bus.i_resultIdx   = IDX_W'(idx);
      bus.i_resultData  = 8'(data);
      bus.i_resultArq   = arq;
      bus.i_resultValid = 1'b1;
      for (int k = 0; k < 300 && !acc; k++) begin
         @(negedge clk);
         acc = bus.o_resultReady;
         @(posedge clk);
         #1;
      end
      bus.i_resultValid = 1'b0;
      bus.i_resultIdx   = IDX_W'($urandom);
      bus.i_resultData  = 8'($urandom);
      if (!acc) chk("send_timeout", 0, 1);
   endtask

   task automatic wait_idle();
      bit done;
      done = 1'b0;
      for (int k = 0; k < 400 && !done; k++) begin
         @(negedge clk);
         #1;
         done = mq.size() == 0;
      end
      if (!done) chk("idle_timeout", 0, 1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic chk_rec4(input string nm, input int b1, input int b2,
                           input int b3);
      chk({nm, "_len"}, obs.size(), 4);
      if (obs.size() == 4) begin
         chk({nm, "_b0"}, obs[0], 8'h00);
         chk({nm, "_b1"}, obs[1], b1);
         chk({nm, "_b2"}, obs[2], b2);
         chk({nm, "_b3"}, obs[3], b3);
      end
   endtask

   initial begin
      bus.i_resultValid = 1'b0;
      bus.i_resultIdx   = '0;
      bus.i_resultData  = '0;
      bus.i_resultArq   = 1'b0;
      bus.i_byteReady   = 1'b1;
      @(negedge clk);
      chk("rst_valid", bus.o_byteValid, 0);
      chk("rst_data", bus.o_byteData, 8'h00);
      chk("rst_wcnt", wcnt, 0);
      chk("rst_busy", busy, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // plain record, latency and back-to-back bytes
      obs.delete();
      obs_cyc.delete();
      send(5, 8'h3C, 1'b0);
      wait_idle();
      chk_rec4("t1", 8'h05, 8'h00, 8'h3C);
      if (obs_cyc.size() == 4) begin
         chk("t1_first_lat", obs_cyc[0] - acc_cyc, 1);
         chk("t1_last_lat", obs_cyc[3] - acc_cyc, 4);
      end

      // window record first after reset
      do_reset();
      obs.delete();
      send(12'h113, 8'h7F, 1'b1);
      wait_idle();
      chk("t2_len", obs.size(), 6);
      if (obs.size() == 6) begin
         chk("t2_b0", obs[0], 8'h01);
         chk("t2_b1", obs[1], 8'h01);
         chk("t2_b2", obs[2], 8'h00);
         chk("t2_b3", obs[3], 8'h13);
         chk("t2_b4", obs[4], 8'h01);
         chk("t2_b5", obs[5], 8'h7F);
      end
      chk("t2_wcnt", wcnt, 1);

      // byte backpressure in RES1
      obs.delete();
      send(5, 8'hA5, 1'b1);
      @(posedge clk);
      #1;
      bus.i_byteReady = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("t3_hold_valid", bus.o_byteValid, 1);
         chk("t3_hold_data", bus.o_byteData, 8'h05);
         chk("t3_hold_ready", bus.o_resultReady, 0);
         @(posedge clk);
         #1;
      end
      bus.i_byteReady = 1'b1;
      wait_idle();
      chk_rec4("t3", 8'h05, 8'h00, 8'hA5);

      // clock gate mid-record
      obs.delete();
      send(5, 8'h11, 1'b1);
      @(posedge clk);
      #1;
      cg = 1'b0;
      repeat (4) begin
         @(negedge clk);
         chk("t4_cg_valid", bus.o_byteValid, 0);
         chk("t4_cg_ready", bus.o_resultReady, 0);
         @(posedge clk);
         #1;
      end
      cg = 1'b1;
      @(negedge clk);
      chk("t4_resume_data", bus.o_byteData, 8'h05);
      wait_idle();
      chk_rec4("t4", 8'h05, 8'h00, 8'h11);

      // reset during RES2
      send(12'h1AB, 8'h22, 1'b1);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk("t5_res2_data", bus.o_byteData, 8'h01);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("t5_valid", bus.o_byteValid, 0);
      chk("t5_busy", busy, 0);
      chk("t5_wcnt", wcnt, 0);
      @(posedge clk);
      #1;
      obs.delete();
      send(12'h042, 8'h99, 1'b0);
      wait_idle();
      chk_rec4("t5", 8'h42, 8'h00, 8'h99);

      // 256 toggles: window count wraps
      do_reset();
      for (int i = 0; i < 256; i++) begin
         obs.delete();
         send(i, i, (i % 2) == 0);
         wait_idle();
         chk("t6_len", obs.size(), 6);
         if (obs.size() == 6) begin
            chk("t6_type", obs[0], 8'h01);
            chk("t6_count", obs[1], (i + 1) % 256);
         end
      end
      @(negedge clk);
      chk("t6_wrap", wcnt, 0);
      @(posedge clk);
      #1;

      // randomized traffic with gating, backpressure and rare resets
      begin
         bit arq;
         arq = 1'b0;
         rnd_en = 1'b1;
         for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) < 30) arq = ~arq;
            send($urandom_range(0, 275), $urandom_range(0, 255), arq);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            if ($urandom_range(0, 99) < 3) begin
               do_reset();
               arq = 1'b0;
            end
         end
         rnd_en = 1'b0;
         @(posedge clk);
         #2;
         cg = 1'b1;
         bus.i_byteReady = 1'b1;
         wait_idle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/corrdet_resultpack.md
Name: corrdet_resultpack

Overview:
- Consumer end of the corrdet result stream.
- Accepts (idx, data, arq) results over valid/ready and packs them into fixed-format byte records on a byte-wide valid/ready stream for the host bytepipe (USB/UART bridge).
- Inserts a window record whenever arq toggles, so the host can delimit analysis windows without extra sideband signals.

Parameters:
- N_RESULTS, 276, number of result slots produced upstream; must be >= 2 and <= 65536.
- IDX_W, $clog2(N_RESULTS), width of i_resultIdx; must be <= 16.
- DATA_W, 8, width of i_resultData; must be <= 8; zero-extended to 8 bits on output.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  reset: synchronous, active-high, sampled on rising i_clk.
- i_cg  input  1  clock-gate enable; 0 freezes all state.
- i_resultValid  input  1  upstream result valid.
- o_resultReady  output  1  result accept; combinational from state and i_cg.
- i_resultIdx  input  IDX_W  result index.
- i_resultData  input  DATA_W  result value.
- i_resultArq  input  1  window-boundary toggle from producer.
- o_byteValid  output  1  output byte valid.
- i_byteReady  input  1  downstream byte accept.
- o_byteData  output  8  output byte.
- o_windowCount  output  8  count of window records emitted; wraps 255->0.
- o_busy  output  1  1 while any record is in flight (state != IDLE).

Behaviour:
- Single clock domain. Synchronous active-high reset on i_rst. Reset has priority over i_cg.
- Reset values:
  - state = IDLE; o_byteValid = 0; o_byteData = 0x00.
  - o_windowCount = 0; lastArq = 0; o_busy = 0.
  - All capture registers = 0.
- i_cg = 0:
  - No register updates.
  - o_resultReady and o_byteValid forced 0, so no handshake completes on either side.
- Record formats:
  - Result record, 4 bytes in order: 0x00, idx[7:0], idx[15:8] (zero-extended), data (zero-extended).
  - Window record, 2 bytes in order: 0x01, new windowCount value.
- States: IDLE, WIN0, WIN1, RES0, RES1, RES2, RES3.
- IDLE:
  - o_resultReady = 1 (when i_cg = 1).
  - On i_resultValid & o_resultReady: capture idx, data and arq.
  - If arq != lastArq: set lastArq = arq, increment windowCount, go to WIN0.
  - Otherwise go to RES0.
- WIN0, WIN1, RES0..RES3:
  - o_byteValid = 1 with the corresponding byte, driven from registered capture data.
  - Advance to the next state only on o_byteValid & i_byteReady. Otherwise hold with byte and valid stable.
  - WIN1 goes to RES0; RES3 goes to IDLE.
  - o_resultReady = 0 in all these states.
- Window bookkeeping:
  - windowCount increments in the capture cycle.
  - The WIN1 byte and o_windowCount show the incremented value from the next cycle.
- Latency and throughput:
  - Result captured in cycle N gives the first byte valid in cycle N+1.
  - With i_byteReady held 1: 4 bytes in N+1..N+4 and IDLE in N+5, so one result per 5 cycles.
  - A window-boundary result adds 2 cycles.
- No result is ever dropped; backpressure propagates fully upstream.
- Simultaneous arq toggle and result: the window record always precedes that result's record.
- Reset mid-record: the partial record is abandoned. The host resynchronises on the next type byte after the link reset.
- First result after reset: arq = 0 gives no window record; arq = 1 gives a window record with count 1.
- Input values are sampled only on the accept cycle; changes while not ready are ignored.

Test Plan:
- Reset, then result idx=5, data=0x3C, arq=0, byteReady=1 -> bytes 0x00,0x05,0x00,0x3C in consecutive cycles starting 1 cycle after accept; ready returns the cycle after the last byte.
- Result idx=0x113, data=0x7F, arq=1 after reset -> bytes 0x01,0x01,0x00,0x13,0x01,0x7F; o_windowCount=1.
- Byte backpressure: byteReady low for 3 cycles during RES1 -> byte 0x05 held stable, o_resultReady stays 0, and no byte is duplicated or skipped.
- Arq toggled 256 times, with one result each -> window bytes run 0x01..0xFF then 0x00; o_windowCount wraps to 0.
- i_cg=0 for 4 cycles mid-record -> o_byteValid=0 and o_resultReady=0 throughout; on return, output resumes from the same byte with state unchanged.
- i_rst asserted during RES2 -> next cycle o_byteValid=0, o_busy=0, o_windowCount=0; next result with arq=0 emits a plain 4-byte record.
